// File: rtl/dm_sram_responder.sv
// Data-memory responder: 1-cycle reads, bit-masked writes, clear-on-reset.
// Optional per-byte even parity guarded by DM_PARITY_EN.
module dm_sram_responder #(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 1 << ADDR_W,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_data_in,
  input  logic              dm_web,
  input  logic [31:0]       dm_bweb,
  output logic [31:0]       dm_data_out,
  output logic              init_done,
  input  logic              parity_inj,
  output logic              parity_err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       rd_word;
  logic              wr_en;
  logic              init_last;

  assign old_word  = mem[dm_addr];
  assign merged    = (old_word & dm_bweb)
                   | (dm_data_in & ~dm_bweb);
  assign wr_en     = (state == ST_RUN) && !dm_web;
  assign rd_word   = wr_en ? merged : old_word;
  assign init_last = init_cnt == ADDR_W'(DEPTH - 1);

  // Sequencer: sweep init_cnt over the array, then stay in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
      if (init_last) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Array write port: clearing in INIT, masked CPU writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[init_cnt] <= INIT_VAL;
      else if (!dm_web)
        mem[dm_addr] <= merged;
    end
  end

  // Registered read, write-first; held at 0 until clearing ends.
  always_ff @(posedge clk) begin
    if (rst || state == ST_INIT)
      dm_data_out <= '0;
    else
      dm_data_out <= rd_word;
  end

`ifdef DM_PARITY_EN
  function automatic logic [3:0] par4(input logic [31:0] w);
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
  endfunction

  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_new;
  logic [3:0] par_rd;
  logic       par_bad;

  // Injection flips byte-0 parity of the word being written.
  assign par_new = par4(merged) ^ {3'b000, parity_inj};
  assign par_rd  = wr_en ? par_new : par_mem[dm_addr];
  assign par_bad = par_rd != par4(rd_word);

  // Parity array tracks the data array write-for-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        par_mem[init_cnt] <= par4(INIT_VAL);
      else if (!dm_web)
        par_mem[dm_addr] <= par_new;
    end
  end

  // Sticky error flag, checked against the word loaded into dm_data_out.
  always_ff @(posedge clk) begin
    if (rst)
      parity_err <= 1'b0;
    else if (state == ST_RUN && par_bad)
      parity_err <= 1'b1;
  end
`else
  logic unused_inj;
  assign unused_inj = parity_inj;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_sram_responder.sv
// Directed bench for dm_sram_responder at ADDR_W=4.
// Parity expectations follow DM_PARITY_EN.
module tb_dm_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dm_addr;
  logic [31:0] dm_data_in;
  logic        dm_web;
  logic [31:0] dm_bweb;
  logic [31:0] dm_data_out;
  logic        init_done;
  logic        parity_inj;
  logic        parity_err;

  int checks = 0;
  int errors = 0;

`ifdef DM_PARITY_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  dm_sram_responder #(.ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .dm_addr(dm_addr),
    .dm_data_in(dm_data_in),
    .dm_web(dm_web),
    .dm_bweb(dm_bweb),
    .dm_data_out(dm_data_out),
    .init_done(init_done),
    .parity_inj(parity_inj),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [31:0] m);
    dm_addr    = a;
    dm_data_in = d;
    dm_bweb    = m;
    dm_web     = 1'b0;
    tick();
    dm_web     = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a);
    dm_addr = a;
    dm_web  = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    dm_addr    = '0;
    dm_data_in = '0;
    dm_web     = 1'b1;
    dm_bweb    = '1;
    parity_inj = 1'b0;
    tick();
    tick();
    chk("rst_out", dm_data_out, 32'h0);
    chk("rst_done", {31'b0, init_done}, 32'h0);
    chk("rst_perr", {31'b0, parity_err}, 32'h0);

    // Clearing; a stray write during INIT must be dropped.
    rst        = 1'b0;
    dm_addr    = 4'd2;
    dm_data_in = 32'hFFFF_FFFF;
    dm_bweb    = 32'h0;
    dm_web     = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("init_done_%0d", i),
          {31'b0, init_done}, (i == 16) ? 32'h1 : 32'h0);
      chk($sformatf("init_out_%0d", i), dm_data_out, 32'h0);
    end
    dm_web  = 1'b1;
    dm_bweb = '1;

    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk($sformatf("clear_rd_%0d", a), dm_data_out, 32'h0);
    end

    wr(4'd5, 32'hDEAD_BEEF, 32'h0);
    chk("full_wr_first", dm_data_out, 32'hDEAD_BEEF);
    rd(4'd5);
    chk("full_rd", dm_data_out, 32'hDEAD_BEEF);

    wr(4'd5, 32'h1122_3344, 32'hFFFF_00FF);
    chk("byte_wr_first", dm_data_out, 32'hDEAD_33EF);
    rd(4'd5);
    chk("byte_rd", dm_data_out, 32'hDEAD_33EF);

    wr(4'd5, 32'h0, 32'hFFFF_FFFF);
    chk("noop_wr", dm_data_out, 32'hDEAD_33EF);
    rd(4'd5);
    chk("noop_rd", dm_data_out, 32'hDEAD_33EF);

    wr(4'd7, 32'hA5A5_A5A5, 32'hFFFF_0000);
    chk("collide", dm_data_out, 32'h0000_A5A5);
    rd(4'd6);
    chk("neigh_rd", dm_data_out, 32'h0);
    rd(4'd7);
    chk("collide_rd", dm_data_out, 32'h0000_A5A5);

    wr(4'd15, 32'h8000_0001, 32'h0);
    rd(4'd15);
    chk("top_rd", dm_data_out, 32'h8000_0001);
    rd(4'd0);
    chk("bot_rd", dm_data_out, 32'h0);
    chk("perr_clean", {31'b0, parity_err}, 32'h0);

    parity_inj = 1'b1;
    wr(4'd3, 32'h1234_5678, 32'h0);
    parity_inj = 1'b0;
    chk("inj_wr", dm_data_out, 32'h1234_5678);
    rd(4'd3);
    chk("inj_rd", dm_data_out, 32'h1234_5678);
    chk("perr_set", {31'b0, parity_err}, {31'b0, PE});
    rd(4'd5);
    chk("perr_sticky1", {31'b0, parity_err}, {31'b0, PE});
    wr(4'd3, 32'h0F0F_0F0F, 32'h0);
    rd(4'd3);
    chk("clean_rewrite", dm_data_out, 32'h0F0F_0F0F);
    chk("perr_sticky2", {31'b0, parity_err}, {31'b0, PE});

    // Reset mid-operation restarts clearing from entry 0.
    dm_addr = 4'd5;
    rst     = 1'b1;
    tick();
    chk("mid_rst_done", {31'b0, init_done}, 32'h0);
    chk("mid_rst_out", dm_data_out, 32'h0);
    chk("mid_rst_perr", {31'b0, parity_err}, 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    chk("reinit_15", {31'b0, init_done}, 32'h0);
    tick();
    chk("reinit_16", {31'b0, init_done}, 32'h1);
    rd(4'd5);
    chk("reinit_rd5", dm_data_out, 32'h0);
    rd(4'd3);
    chk("reinit_rd3", dm_data_out, 32'h0);
    chk("reinit_perr", {31'b0, parity_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
